counter_64: RTL and testbench

- Free-running 64-bit cycle counter used by driver/harness logic to timestamp events and measure accelerator run time, e.g. from start to done.
- Adds start/end timestamp capture, a registered elapsed-cycle result and a wrap indicator on top of the basic count.
- Sits beside the accelerator top as a pure observation block; it drives no datapath.

---
 rtl/counter_64_if.sv | 60 ++++++
 rtl/counter_64.sv | 118 +++++++++++
 tb/tb_counter_64.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/counter_64_if.sv
// rtl/counter_64_if.sv - control and observation bundle for the counter_64 cycle counter
//
// Purpose: groups the counter's control strobes and its registered results so
// that the harness side (master) and the counter (slave) share one port.
//
// Signals:
//   increment     master->slave  advance count by one this cycle
//   clear         master->slave  synchronous reload of count to INIT
//   capture_start master->slave  latch start timestamp, arm measurement
//   capture_end   master->slave  latch end timestamp, produce elapsed
//   count         slave->master  current counter value
//   start_cycle   slave->master  last captured start timestamp
//   end_cycle     slave->master  last captured end timestamp
//   elapsed       slave->master  end minus start of last completed measurement
//   elapsed_valid slave->master  one-cycle pulse when elapsed updates
//   running       slave->master  measurement armed
//   wrap          slave->master  one-cycle pulse after count rolls over to zero
interface counter_64_if #(
    parameter int WIDTH = 64
);
    logic             increment;
    logic             clear;
    logic             capture_start;
    logic             capture_end;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] start_cycle;
    logic [WIDTH-1:0] end_cycle;
    logic [WIDTH-1:0] elapsed;
    logic             elapsed_valid;
    logic             running;
    logic             wrap;

    modport master (
        output increment,
        output clear,
        output capture_start,
        output capture_end,
        input  count,
        input  start_cycle,
        input  end_cycle,
        input  elapsed,
        input  elapsed_valid,
        input  running,
        input  wrap
    );

    modport slave (
        input  increment,
        input  clear,
        input  capture_start,
        input  capture_end,
        output count,
        output start_cycle,
        output end_cycle,
        output elapsed,
        output elapsed_valid,
        output running,
        output wrap
    );
endinterface

// File: rtl/counter_64.sv
// rtl/counter_64.sv - free-running cycle counter with start/end timestamp capture
//
// Purpose: counts clock cycles and measures the distance between a start and
// an end capture. Pure observation block; it drives no datapath.
//
// Ports:
//   clk  - single clock, all state changes on its rising edge
//   rst  - asynchronous, active-low reset
//   bus  - counter_64_if slave modport (controls in, registered results out)
//
// Parameters:
//   WIDTH - counter and timestamp width (must match the interface WIDTH)
//   INIT  - count value loaded on reset and on clear
module counter_64 #(
    parameter int               WIDTH = 64,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic         clk,
    input  logic         rst,
    counter_64_if.slave  bus
);

    // Measurement state: IDLE until a start is captured, ARMED until an end.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] start_cycle_q, start_cycle_d;
    logic [WIDTH-1:0] end_cycle_q, end_cycle_d;
    logic [WIDTH-1:0] elapsed_q, elapsed_d;
    logic             elapsed_valid_q, elapsed_valid_d;
    logic             wrap_q, wrap_d;

    // An end only counts when a measurement is armed; it is evaluated before
    // any same-cycle start so it pairs with the previous start timestamp.
    logic end_fire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            count_q         <= INIT;
            start_cycle_q   <= '0;
            end_cycle_q     <= '0;
            elapsed_q       <= '0;
            elapsed_valid_q <= 1'b0;
            wrap_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            start_cycle_q   <= start_cycle_d;
            end_cycle_q     <= end_cycle_d;
            elapsed_q       <= elapsed_d;
            elapsed_valid_q <= elapsed_valid_d;
            wrap_q          <= wrap_d;
        end
    end

    // Counter: clear beats increment; the add wraps naturally at WIDTH bits.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (bus.clear) begin
            count_d = INIT;
        end else if (bus.increment) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
            wrap_d  = (count_q == {WIDTH{1'b1}});
        end
    end

    // Measurement FSM and capture registers. All captures use the count as
    // it was before this edge's update.
    always_comb begin
        state_d         = state_q;
        start_cycle_d   = start_cycle_q;
        end_cycle_d     = end_cycle_q;
        elapsed_d       = elapsed_q;
        elapsed_valid_d = 1'b0;
        end_fire        = bus.capture_end && (state_q == ST_ARMED);

        if (end_fire) begin
            end_cycle_d     = count_q;
            // Modulo subtraction keeps the result right across one wrap.
            elapsed_d       = count_q - start_cycle_q;
            elapsed_valid_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.capture_start) begin
                    start_cycle_d = count_q;
                    state_d       = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // A start while armed re-arms, even alongside an end.
                if (bus.capture_start) begin
                    start_cycle_d = count_q;
                    state_d       = ST_ARMED;
                end else if (end_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.count         = count_q;
    assign bus.start_cycle   = start_cycle_q;
    assign bus.end_cycle     = end_cycle_q;
    assign bus.elapsed       = elapsed_q;
    assign bus.elapsed_valid = elapsed_valid_q;
    assign bus.running       = (state_q == ST_ARMED);
    assign bus.wrap          = wrap_q;

endmodule

// File: tb/tb_counter_64.sv
// tb/tb_counter_64.sv - self-checking bench for counter_64
module tb_counter_64;

    localparam logic [63:0] WINIT = 64'hFFFF_FFFF_FFFF_FFFE;

    logic clk;
    logic rst;

    counter_64_if #(.WIDTH(64)) bi ();
    counter_64_if #(.WIDTH(64)) bw ();

    counter_64 #(.WIDTH(64), .INIT(64'd0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bi.slave)
    );

    counter_64 #(.WIDTH(64), .INIT(WINIT)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (bw.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model of the INIT=0 instance.
    logic [63:0] m_count, m_start, m_end, m_elapsed;
    logic        m_running, m_valid, m_wrap;

    task automatic model_reset();
        m_count = 64'd0; m_start = 64'd0; m_end = 64'd0; m_elapsed = 64'd0;
        m_running = 1'b0; m_valid = 1'b0; m_wrap = 1'b0;
    endtask

    // Advance one clock; sample 1 ns after the edge and update the model from
    // the inputs that were present at that edge.
    task automatic tick();
        logic [63:0] old;
        logic        fire;
        @(posedge clk);
        #1;
        old  = m_count;
        fire = bi.capture_end && m_running;
        m_valid = fire;
        if (fire) begin
            m_end     = old;
            m_elapsed = old - m_start;
        end
        if (bi.capture_start) begin
            m_start   = old;
            m_running = 1'b1;
        end else if (fire) begin
            m_running = 1'b0;
        end
        m_wrap  = !bi.clear && bi.increment && (old + 64'd1 == 64'd0);
        m_count = bi.clear ? 64'd0 : old + {63'd0, bi.increment};
    endtask

    task automatic run_to(input logic [63:0] target);
        int n = 0;
        while (m_count != target && n < 300) begin
            tick();
            n++;
        end
        if (m_count != target) begin
            total++; bad++;
            $display("FAIL run_to timeout got=%0d need=%0d", m_count, target);
        end
    endtask

    task automatic pulse_start();
        bi.capture_start = 1'b1; tick(); bi.capture_start = 1'b0;
    endtask

    task automatic pulse_end();
        bi.capture_end = 1'b1; tick(); bi.capture_end = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bi.count !== 64'd0) begin bad++; $display("FAIL reset_count got=%h exp=0", bi.count); end
        total++; if (bw.count !== WINIT) begin bad++; $display("FAIL reset_init got=%h exp=%h", bw.count, WINIT); end
        total++; if ({bi.start_cycle, bi.end_cycle, bi.elapsed} !== 192'd0) begin bad++; $display("FAIL reset_regs got=%h/%h/%h exp=0", bi.start_cycle, bi.end_cycle, bi.elapsed); end
        total++; if ({bi.elapsed_valid, bi.running, bi.wrap} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {bi.elapsed_valid, bi.running, bi.wrap}); end
        rst = 1'b1;
        model_reset();
        bi.increment = 1'b1;
        repeat (10) tick();
        total++; if (bi.count !== 64'd10) begin bad++; $display("FAIL count10 got=%0d exp=10", bi.count); end
        total++; if ({bi.wrap, bi.running} !== 2'b00) begin bad++; $display("FAIL count10_flags got=%b exp=00", {bi.wrap, bi.running}); end
        #3 rst = 1'b0;
        #1;
        total++; if (bi.count !== 64'd0) begin bad++; $display("FAIL async_reset got=%0d exp=0", bi.count); end
        @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
    endtask

    task automatic test_measure();
        run_to(64'd5);
        pulse_start();
        total++; if (bi.start_cycle !== 64'd5 || bi.running !== 1'b1) begin bad++; $display("FAIL meas_start got=%0d/%b exp=5/1", bi.start_cycle, bi.running); end
        run_to(64'd105);
        pulse_end();
        total++; if (bi.end_cycle !== 64'd105) begin bad++; $display("FAIL meas_end got=%0d exp=105", bi.end_cycle); end
        total++; if (bi.elapsed !== 64'd100) begin bad++; $display("FAIL meas_elapsed got=%0d exp=100", bi.elapsed); end
        total++; if (bi.elapsed_valid !== 1'b1 || bi.running !== 1'b0) begin bad++; $display("FAIL meas_pulse got=%b/%b exp=1/0", bi.elapsed_valid, bi.running); end
        tick();
        total++; if (bi.elapsed_valid !== 1'b0) begin bad++; $display("FAIL meas_pulse_width got=%b exp=0", bi.elapsed_valid); end
    endtask

    task automatic test_wrap();
        bw.clear = 1'b1; bw.increment = 1'b1;
        tick();
        bw.clear = 1'b0;
        total++; if (bw.count !== WINIT) begin bad++; $display("FAIL wrap_clear got=%h exp=%h", bw.count, WINIT); end
        bw.capture_start = 1'b1;
        tick();
        bw.capture_start = 1'b0;
        total++; if (bw.count !== 64'hFFFF_FFFF_FFFF_FFFF || bw.wrap !== 1'b0) begin bad++; $display("FAIL wrap_ones got=%h/%b exp=ff..ff/0", bw.count, bw.wrap); end
        tick();
        total++; if (bw.count !== 64'd0 || bw.wrap !== 1'b1) begin bad++; $display("FAIL wrap_zero got=%h/%b exp=0/1", bw.count, bw.wrap); end
        tick();
        total++; if (bw.count !== 64'd1 || bw.wrap !== 1'b0) begin bad++; $display("FAIL wrap_once got=%h/%b exp=1/0", bw.count, bw.wrap); end
        repeat (2) tick();
        bw.capture_end = 1'b1;
        tick();
        bw.capture_end = 1'b0;
        total++; if (bw.elapsed !== 64'd5 || bw.end_cycle !== 64'd3 || bw.elapsed_valid !== 1'b1) begin bad++; $display("FAIL wrap_elapsed got=%0d/%0d/%b exp=5/3/1", bw.elapsed, bw.end_cycle, bw.elapsed_valid); end
        bw.increment = 1'b0;
    endtask

    task automatic test_hold_clear();
        logic [63:0] held;
        int          moved = 0;
        logic [63:0] e_end, e_el;
        bi.increment = 1'b0;
        tick();
        held = m_count;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bi.count !== held) moved++;
        end
        total++; if (moved != 0) begin bad++; $display("FAIL hold cycles_moved=%0d exp=0 count=%0d", moved, bi.count); end
        bi.clear = 1'b1; bi.increment = 1'b1;
        tick();
        bi.clear = 1'b0;
        total++; if (bi.count !== 64'd0) begin bad++; $display("FAIL clear_prio got=%0d exp=0", bi.count); end
        e_end = m_end; e_el = m_elapsed;
        pulse_end();
        total++; if (bi.end_cycle !== e_end || bi.elapsed !== e_el || bi.elapsed_valid !== 1'b0) begin bad++; $display("FAIL idle_end got=%0d/%0d/%b exp=%0d/%0d/0", bi.end_cycle, bi.elapsed, bi.elapsed_valid, e_end, e_el); end
    endtask

    task automatic test_back_to_back();
        bi.clear = 1'b1; tick(); bi.clear = 1'b0;
        run_to(64'd10);
        pulse_start();
        run_to(64'd30);
        bi.capture_start = 1'b1; bi.capture_end = 1'b1;
        tick();
        bi.capture_start = 1'b0; bi.capture_end = 1'b0;
        total++; if (bi.elapsed !== 64'd20 || bi.elapsed_valid !== 1'b1) begin bad++; $display("FAIL b2b_elapsed got=%0d/%b exp=20/1", bi.elapsed, bi.elapsed_valid); end
        total++; if (bi.start_cycle !== 64'd30 || bi.running !== 1'b1) begin bad++; $display("FAIL b2b_rearm got=%0d/%b exp=30/1", bi.start_cycle, bi.running); end
        run_to(64'd50);
        pulse_end();
        total++; if (bi.elapsed !== 64'd20 || bi.end_cycle !== 64'd50) begin bad++; $display("FAIL b2b_second got=%0d/%0d exp=20/50", bi.elapsed, bi.end_cycle); end
    endtask

    task automatic test_restart();
        bi.clear = 1'b1; tick(); bi.clear = 1'b0;
        run_to(64'd7);
        pulse_start();
        run_to(64'd12);
        pulse_start();
        run_to(64'd40);
        pulse_end();
        total++; if (bi.elapsed !== 64'd28 || bi.end_cycle !== 64'd40) begin bad++; $display("FAIL restart got=%0d/%0d exp=28/40", bi.elapsed, bi.end_cycle); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            bi.increment     = ($urandom_range(0, 3) != 0);
            bi.clear         = ($urandom_range(0, 29) == 0);
            bi.capture_start = ($urandom_range(0, 9) == 0);
            bi.capture_end   = ($urandom_range(0, 7) == 0);
            tick();
            total++; if (bi.count !== m_count) begin bad++; $display("FAIL rand_count c=%0d got=%h exp=%h", c, bi.count, m_count); end
            total++; if (bi.start_cycle !== m_start) begin bad++; $display("FAIL rand_start c=%0d got=%h exp=%h", c, bi.start_cycle, m_start); end
            total++; if (bi.end_cycle !== m_end) begin bad++; $display("FAIL rand_end c=%0d got=%h exp=%h", c, bi.end_cycle, m_end); end
            total++; if (bi.elapsed !== m_elapsed) begin bad++; $display("FAIL rand_elapsed c=%0d got=%h exp=%h", c, bi.elapsed, m_elapsed); end
            total++; if ({bi.elapsed_valid, bi.running, bi.wrap} !== {m_valid, m_running, m_wrap}) begin bad++; $display("FAIL rand_flags c=%0d got=%b exp=%b", c, {bi.elapsed_valid, bi.running, bi.wrap}, {m_valid, m_running, m_wrap}); end
        end
        bi.increment = 1'b0; bi.clear = 1'b0; bi.capture_start = 1'b0; bi.capture_end = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        bi.increment = 1'b0; bi.clear = 1'b0; bi.capture_start = 1'b0; bi.capture_end = 1'b0;
        bw.increment = 1'b0; bw.clear = 1'b0; bw.capture_start = 1'b0; bw.capture_end = 1'b0;
        model_reset();
        test_reset();
        test_measure();
        test_wrap();
        test_hold_clear();
        test_back_to_back();
        test_restart();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
